// File: rtl/ide_cycle_pkg.sv
// Shared types and cycle-timing defaults for the IDE board bus-cycle controller.
package ide_cycle_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        ROM     = 3'd3,
        ACK     = 3'd4,
        WAIT_AS = 3'd5
    } state_t;

    localparam logic REGION_ROM = 1'b0;
    localparam logic REGION_ATA = 1'b1;

    localparam int unsigned SETUP_CYC_DEF     = 1;
    localparam int unsigned STROBE_CYC_DEF    = 3;
    localparam int unsigned ROM_CYC_DEF       = 2;
    localparam int unsigned IORDY_TIMEOUT_DEF = 16;

    // Address/direction captured when a cycle is accepted.
    typedef struct packed {
        logic [7:0] a_high;
        logic [3:0] a_mid;
        logic       rw;
    } cyc_lat_t;

    // Registered pin image; every field idles at 1 (BUF_DIR idles towards the CPU).
    typedef struct packed {
        logic cs0_n;
        logic cs1_n;
        logic ior_n;
        logic iow_n;
        logic rom_oe_n;
        logic buf_oe_n;
        logic buf_dir;
        logic dtack_n;
    } bus_out_t;

    localparam bus_out_t OUT_IDLE = '1;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with a configurable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ide_cycle_ctrl.sv
// Bus-cycle controller for the IDE board window: boot ROM (lower 32 KB) and ATA registers (upper 32 KB).
// Optional IORDY strobe extension is compiled in with `define IDE_IORDY_EN.
import ide_cycle_pkg::*;

module ide_cycle_ctrl #(
    parameter int unsigned SETUP_CYC     = SETUP_CYC_DEF,
    parameter int unsigned STROBE_CYC    = STROBE_CYC_DEF,
    parameter int unsigned ROM_CYC       = ROM_CYC_DEF,
    parameter int unsigned IORDY_TIMEOUT = IORDY_TIMEOUT_DEF
) (
    input  logic       C7M,
    input  logic       RESET,
    input  logic       AS_CPU_n,
    input  logic       DS_n,
    input  logic       RW_n,
    input  logic [7:0] A_HIGH,
    input  logic [3:0] A_MID,
    input  logic [7:0] BASE_IDE,
    input  logic       IDE_CONFIGURED_n,
    input  logic       ROM_EN,
    input  logic       IORDY,
    output logic       IDE_CS0_n,
    output logic       IDE_CS1_n,
    output logic       IDE_IOR_n,
    output logic       IDE_IOW_n,
    output logic       ROM_OE_n,
    output logic       BUF_OE_n,
    output logic       BUF_DIR,
    output logic       DTACK_n
);

    localparam int unsigned CNT_MAX = max2(max2(SETUP_CYC, STROBE_CYC), max2(ROM_CYC, IORDY_TIMEOUT));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    cyc_lat_t         lat, lat_nx;
    logic             ext, ext_nx;
    bus_out_t         out_q, out_nx;
    logic             as_s;
    logic             hit_c;
    logic             rom_drive_c;

    sync2 #(.RST_VAL(1'b1)) u_as_sync (
        .clk (C7M),
        .rst (RESET),
        .d   (AS_CPU_n),
        .q   (as_s)
    );

    assign hit_c = !as_s && !DS_n && !IDE_CONFIGURED_n && (A_HIGH == BASE_IDE);

    // Latched high address and the unused A_MID bits are kept for visibility only.
    logic unused_lat;
    assign unused_lat = ^{lat.a_high, lat.a_mid[2:1]};

`ifndef IDE_IORDY_EN
    logic unused_iordy;
    assign unused_iordy = IORDY;
`endif

    always_ff @(posedge C7M) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            lat   <= '0;
            ext   <= 1'b0;
            out_q <= OUT_IDLE;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            lat   <= lat_nx;
            ext   <= ext_nx;
            out_q <= out_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        lat_nx      = lat;
        ext_nx      = ext;
        out_nx      = OUT_IDLE;
        rom_drive_c = 1'b0;

        case (state)
            IDLE: begin
                if (hit_c) begin
                    lat_nx = '{a_high: A_HIGH, a_mid: A_MID, rw: RW_n};
                    if (A_MID[3] == REGION_ATA) begin
                        state_nx = SETUP;
                        cnt_nx   = CNT_W'(SETUP_CYC - 1);
                    end else begin
                        state_nx = ROM;
                        cnt_nx   = (ROM_EN && RW_n) ? CNT_W'(ROM_CYC - 1) : '0;
                    end
                end
            end
            SETUP: begin
                if (as_s) begin
                    state_nx = IDLE;
                end else if (cnt == '0) begin
                    state_nx = STROBE;
                    cnt_nx   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (as_s) begin
                    state_nx = IDLE;
`ifdef IDE_IORDY_EN
                end else if (ext) begin
                    if (IORDY || cnt == '0) begin
                        state_nx = ACK;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (!IORDY) begin
                    ext_nx = 1'b1;
                    cnt_nx = CNT_W'(IORDY_TIMEOUT - 1);
`else
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
`endif
                end else begin
                    state_nx = ACK;
                    cnt_nx   = '0;
                end
            end
            ROM: begin
                if (as_s) begin
                    state_nx = IDLE;
                end else if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    state_nx = ACK;
                    cnt_nx   = '0;
                end
            end
            ACK: begin
                state_nx = WAIT_AS;
                cnt_nx   = '0;
            end
            WAIT_AS: begin
                if (as_s) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (state_nx == IDLE) begin
            cnt_nx = '0;
            ext_nx = 1'b0;
        end
        if (state_nx == ACK) begin
            ext_nx = 1'b0;
        end

        // Output image for the state being entered, so pins switch on the same edge as the state.
        rom_drive_c = ROM_EN && lat_nx.rw;
        case (state_nx)
            SETUP, STROBE: begin
                out_nx.cs0_n    = lat_nx.a_mid[0];
                out_nx.cs1_n    = !lat_nx.a_mid[0];
                out_nx.buf_oe_n = 1'b0;
                out_nx.buf_dir  = lat_nx.rw;
                if (state_nx == STROBE) begin
                    out_nx.ior_n = !lat_nx.rw;
                    out_nx.iow_n = lat_nx.rw;
                end
            end
            ROM: begin
                if (rom_drive_c) begin
                    out_nx.rom_oe_n = 1'b0;
                    out_nx.buf_oe_n = 1'b0;
                    out_nx.buf_dir  = lat_nx.rw;
                end
            end
            ACK: begin
                out_nx.dtack_n = 1'b0;
                if (lat_nx.a_mid[3] == REGION_ATA) begin
                    out_nx.cs0_n    = lat_nx.a_mid[0];
                    out_nx.cs1_n    = !lat_nx.a_mid[0];
                    out_nx.buf_oe_n = 1'b0;
                    out_nx.buf_dir  = lat_nx.rw;
                end else if (rom_drive_c) begin
                    out_nx.buf_oe_n = 1'b0;
                    out_nx.buf_dir  = lat_nx.rw;
                end
            end
            WAIT_AS: begin
                out_nx.dtack_n = 1'b0;
            end
            default: begin
                out_nx = OUT_IDLE;
            end
        endcase
    end

    assign IDE_CS0_n = out_q.cs0_n;
    assign IDE_CS1_n = out_q.cs1_n;
    assign IDE_IOR_n = out_q.ior_n;
    assign IDE_IOW_n = out_q.iow_n;
    assign ROM_OE_n  = out_q.rom_oe_n;
    assign BUF_OE_n  = out_q.buf_oe_n;
    assign BUF_DIR   = out_q.buf_dir;
    assign DTACK_n   = out_q.dtack_n;

endmodule

// File: tb/tb_ide_cycle_ctrl.sv
// Directed bench for ide_cycle_ctrl: per-edge pin images checked against hand-derived values.
// Pin image bit order: {CS0_n, CS1_n, IOR_n, IOW_n, ROM_OE_n, BUF_OE_n, BUF_DIR, DTACK_n}.
module tb_ide_cycle_ctrl;

    logic       C7M = 1'b0;
    logic       RESET;
    logic       AS_CPU_n;
    logic       DS_n;
    logic       RW_n;
    logic [7:0] A_HIGH;
    logic [3:0] A_MID;
    logic [7:0] BASE_IDE;
    logic       IDE_CONFIGURED_n;
    logic       ROM_EN;
    logic       IORDY;
    logic       IDE_CS0_n;
    logic       IDE_CS1_n;
    logic       IDE_IOR_n;
    logic       IDE_IOW_n;
    logic       ROM_OE_n;
    logic       BUF_OE_n;
    logic       BUF_DIR;
    logic       DTACK_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 C7M = ~C7M;

    ide_cycle_ctrl dut (
        .C7M              (C7M),
        .RESET            (RESET),
        .AS_CPU_n         (AS_CPU_n),
        .DS_n             (DS_n),
        .RW_n             (RW_n),
        .A_HIGH           (A_HIGH),
        .A_MID            (A_MID),
        .BASE_IDE         (BASE_IDE),
        .IDE_CONFIGURED_n (IDE_CONFIGURED_n),
        .ROM_EN           (ROM_EN),
        .IORDY            (IORDY),
        .IDE_CS0_n        (IDE_CS0_n),
        .IDE_CS1_n        (IDE_CS1_n),
        .IDE_IOR_n        (IDE_IOR_n),
        .IDE_IOW_n        (IDE_IOW_n),
        .ROM_OE_n         (ROM_OE_n),
        .BUF_OE_n         (BUF_OE_n),
        .BUF_DIR          (BUF_DIR),
        .DTACK_n          (DTACK_n)
    );

    logic [7:0] obs;
    assign obs = {IDE_CS0_n, IDE_CS1_n, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, BUF_OE_n, BUF_DIR, DTACK_n};

    localparam logic [7:0] P_IDLE     = 8'hFF;
    localparam logic [7:0] P_RD_SETUP = 8'h7B;
    localparam logic [7:0] P_RD_STRB  = 8'h5B;
    localparam logic [7:0] P_RD_ACK   = 8'h7A;
    localparam logic [7:0] P_WR_SETUP = 8'hB9;
    localparam logic [7:0] P_WR_STRB  = 8'hA9;
    localparam logic [7:0] P_WR_ACK   = 8'hB8;
    localparam logic [7:0] P_ROM_RD   = 8'hF3;
    localparam logic [7:0] P_ROM_ACK  = 8'hFA;
    localparam logic [7:0] P_DTACK    = 8'hFE;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and compare the pin image shortly after it.
    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge C7M);
        #1;
        check_eq(tag, 32'(obs), 32'(exp));
    endtask

    task automatic run(input string tag, input logic [7:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, exp);
        end
    endtask

    task automatic start(input logic [7:0] ah, input logic [3:0] am, input logic rw);
        A_HIGH   = ah;
        A_MID    = am;
        RW_n     = rw;
        AS_CPU_n = 1'b0;
        DS_n     = 1'b0;
    endtask

    task automatic release_bus();
        AS_CPU_n = 1'b1;
        DS_n     = 1'b1;
    endtask

    initial begin
        RESET            = 1'b1;
        AS_CPU_n         = 1'b1;
        DS_n             = 1'b1;
        RW_n             = 1'b1;
        A_HIGH           = 8'h00;
        A_MID            = 4'h0;
        BASE_IDE         = 8'hE9;
        IDE_CONFIGURED_n = 1'b1;
        ROM_EN           = 1'b1;
        IORDY            = 1'b1;

        run("reset", P_IDLE, 3);
        RESET = 1'b0;
        step("reset_release", P_IDLE);

        // Unconfigured board: a read at $E98000 must not be claimed.
        start(8'hE9, 4'h8, 1'b1);
        run("miss", P_IDLE, 8);
        release_bus();
        run("miss_end", P_IDLE, 3);

        IDE_CONFIGURED_n = 1'b0;

        // Wrong base: $E88000 while the board sits at $E9.
        start(8'hE8, 4'h8, 1'b1);
        run("miss_base", P_IDLE, 6);
        release_bus();
        run("miss_base_end", P_IDLE, 3);

        // ATA read, CS0, at $E98000.
        start(8'hE9, 4'h8, 1'b1);
        run("rd_sync", P_IDLE, 2);
        step("rd_setup", P_RD_SETUP);
        run("rd_strobe", P_RD_STRB, 3);
        step("rd_ack", P_RD_ACK);
        step("rd_wait", P_DTACK);
        release_bus();
        run("rd_wait_as", P_DTACK, 2);
        step("rd_idle", P_IDLE);
        step("rd_gap", P_IDLE);

        // ATA write, CS1, at $E99000.
        start(8'hE9, 4'h9, 1'b0);
        run("wr_sync", P_IDLE, 2);
        step("wr_setup", P_WR_SETUP);
        run("wr_strobe", P_WR_STRB, 3);
        step("wr_ack", P_WR_ACK);
        step("wr_wait", P_DTACK);
        release_bus();
        run("wr_wait_as", P_DTACK, 2);
        step("wr_idle", P_IDLE);

        // ROM read at $E90010 with the ROM enabled.
        start(8'hE9, 4'h0, 1'b1);
        run("rom_sync", P_IDLE, 2);
        run("rom_oe", P_ROM_RD, 2);
        step("rom_ack", P_ROM_ACK);
        step("rom_wait", P_DTACK);
        release_bus();
        run("rom_wait_as", P_DTACK, 2);
        step("rom_idle", P_IDLE);

        // Same read with the ROM jumpered off: acknowledged, nothing driven.
        ROM_EN = 1'b0;
        start(8'hE9, 4'h0, 1'b1);
        run("romoff_sync", P_IDLE, 2);
        step("romoff_rom", P_IDLE);
        step("romoff_ack", P_DTACK);
        step("romoff_wait", P_DTACK);
        release_bus();
        run("romoff_wait_as", P_DTACK, 2);
        step("romoff_idle", P_IDLE);
        ROM_EN = 1'b1;

        // Write into ROM space: acknowledged after one cycle, no output enable.
        start(8'hE9, 4'h0, 1'b0);
        run("romwr_sync", P_IDLE, 2);
        step("romwr_rom", P_IDLE);
        step("romwr_ack", P_DTACK);
        release_bus();
        run("romwr_wait_as", P_DTACK, 2);
        step("romwr_idle", P_IDLE);

        // AS negated in the first strobe cycle: cycle drops to IDLE with no DTACK.
        start(8'hE9, 4'h8, 1'b1);
        run("abort_sync", P_IDLE, 2);
        step("abort_setup", P_RD_SETUP);
        step("abort_strobe0", P_RD_STRB);
        release_bus();
        run("abort_strobe", P_RD_STRB, 2);
        run("abort_idle", P_IDLE, 4);

        // Reset pulsed while waiting for AS negation.
        start(8'hE9, 4'h8, 1'b1);
        run("rstw_sync", P_IDLE, 2);
        step("rstw_setup", P_RD_SETUP);
        run("rstw_strobe", P_RD_STRB, 3);
        step("rstw_ack", P_RD_ACK);
        step("rstw_wait", P_DTACK);
        RESET = 1'b1;
        release_bus();
        step("rstw_reset", P_IDLE);
        RESET = 1'b0;
        run("rstw_after", P_IDLE, 2);

        // Configuration dropped mid-cycle: the running access still completes.
        start(8'hE9, 4'h8, 1'b1);
        run("cfg_sync", P_IDLE, 2);
        step("cfg_setup", P_RD_SETUP);
        IDE_CONFIGURED_n = 1'b1;
        run("cfg_strobe", P_RD_STRB, 3);
        step("cfg_ack", P_RD_ACK);
        step("cfg_wait", P_DTACK);
        release_bus();
        run("cfg_wait_as", P_DTACK, 2);
        step("cfg_idle", P_IDLE);
        IDE_CONFIGURED_n = 1'b0;

`ifdef IDE_IORDY_EN
        // IORDY stuck low: strobe stretches by the full timeout.
        IORDY = 1'b0;
        start(8'hE9, 4'h8, 1'b1);
        run("tmo_sync", P_IDLE, 2);
        step("tmo_setup", P_RD_SETUP);
        run("tmo_strobe", P_RD_STRB, 3 + 16);
        step("tmo_ack", P_RD_ACK);
        step("tmo_wait", P_DTACK);
        release_bus();
        IORDY = 1'b1;
        run("tmo_wait_as", P_DTACK, 2);
        step("tmo_idle", P_IDLE);

        // IORDY released after five extension cycles.
        IORDY = 1'b0;
        start(8'hE9, 4'h8, 1'b1);
        run("rdy_sync", P_IDLE, 2);
        step("rdy_setup", P_RD_SETUP);
        run("rdy_strobe", P_RD_STRB, 3 + 5);
        IORDY = 1'b1;
        step("rdy_ack", P_RD_ACK);
        step("rdy_wait", P_DTACK);
        release_bus();
        run("rdy_wait_as", P_DTACK, 2);
        step("rdy_idle", P_IDLE);
`else
        // IORDY low has no effect without the extension feature.
        IORDY = 1'b0;
        start(8'hE9, 4'h8, 1'b1);
        run("nordy_sync", P_IDLE, 2);
        step("nordy_setup", P_RD_SETUP);
        run("nordy_strobe", P_RD_STRB, 3);
        step("nordy_ack", P_RD_ACK);
        step("nordy_wait", P_DTACK);
        release_bus();
        IORDY = 1'b1;
        run("nordy_wait_as", P_DTACK, 2);
        step("nordy_idle", P_IDLE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ide_cycle_ctrl.md
Name: ide_cycle_ctrl

Overview:
- Downstream consumer of the Zorro II autoconfig stage: takes the assigned 64 KB IDE board base and configured flag.
- Decodes CPU cycles into that window and runs the bus cycle for each hit, clocked on C7M.
- Lower 32 KB is the boot ROM; upper 32 KB is the ATA register file (CS0/CS1).
- Generates ATA strobes, ROM output enable, data-buffer controls and the cycle-terminating DTACK_n.

Parameters:
- SETUP_CYC, 1, C7M cycles of address/CS setup before IOR/IOW asserts (≥1).
- STROBE_CYC, 3, minimum C7M cycles IOR_n/IOW_n held low (≥1).
- ROM_CYC, 2, C7M cycles ROM_OE_n held before DTACK_n asserts (≥1).
- IORDY_TIMEOUT, 16, maximum extra strobe cycles while IORDY is low (IDE_IORDY_EN only).

Ports:
- C7M  in  1  7.09 MHz system clock
- RESET  in  1  synchronous, active-high reset
- AS_CPU_n  in  1  CPU address strobe (asynchronous to C7M)
- DS_n  in  1  data strobe
- RW_n  in  1  1=read, 0=write
- A_HIGH  in  8  A[23:16]
- A_MID  in  4  A[15:12]
- BASE_IDE  in  8  board base A[23:16] from autoconfig
- IDE_CONFIGURED_n  in  1  0 once a base has been assigned
- ROM_EN  in  1  boot ROM fitted/enabled (jumper)
- IORDY  in  1  ATA IORDY, pre-synchronised at top level
- IDE_CS0_n  out  1  ATA command block select
- IDE_CS1_n  out  1  ATA control block select
- IDE_IOR_n  out  1  ATA read strobe
- IDE_IOW_n  out  1  ATA write strobe
- ROM_OE_n  out  1  boot ROM output enable
- BUF_OE_n  out  1  data transceiver enable
- BUF_DIR  out  1  1=IDE→CPU, 0=CPU→IDE
- DTACK_n  out  1  cycle termination to CPU

Behaviour:
- AS_CPU_n passes a 2-flop synchroniser (as_s). Hit evaluation is one cycle later, so hit-to-state-change latency is 3 C7M edges.
- hit = !as_s && !DS_n && !IDE_CONFIGURED_n && A_HIGH==BASE_IDE. Region = A_MID[3]: 0 selects ROM, 1 selects ATA. On ATA hits, A_MID[0] selects CS1 (1) or CS0 (0).
- A_HIGH, A_MID and RW_n are latched on IDLE exit and held for the rest of the cycle.
- Reset, and every output while in IDLE: all *_n outputs = 1, BUF_DIR = 1, counter = 0.
- FSM states: IDLE, SETUP, STROBE, ROM, ACK, WAIT_AS.
  - IDLE: on hit, ATA region goes to SETUP; ROM region goes to ROM. No hit stays in IDLE.
  - SETUP: CSx_n = 0, BUF_DIR = latched RW_n, BUF_OE_n = 0. Count SETUP_CYC cycles, then go to STROBE.
  - STROBE: IOR_n = 0 if read, IOW_n = 0 if write; CS and buffer outputs held. After STROBE_CYC cycles go to ACK. The IORDY extension (optional feature) applies here.
  - ROM: if ROM_EN, ROM_OE_n = 0 and BUF_OE_n = 0 on reads. Count ROM_CYC cycles, then go to ACK.
    - A write, or ROM_EN = 0, goes to ACK after one cycle with ROM_OE_n and BUF_OE_n held at 1; the access is acknowledged but no data is driven.
  - ACK: strobes deasserted. CSx_n and buffer outputs held one more cycle for ATA hold time; DTACK_n = 0. Go to WAIT_AS.
  - WAIT_AS: DTACK_n = 0, all other outputs inactive. When as_s = 1, deassert DTACK_n and go to IDLE.
- Early AS_CPU_n negation (cycle aborted in SETUP, STROBE or ROM): go directly to IDLE next cycle and deassert all outputs. No DTACK is issued.
- Back-to-back cycles: a new hit is only accepted from IDLE, so at least one idle cycle separates accesses.
- IDE_CONFIGURED_n = 1 means no hit is possible. If it rises mid-cycle, the current cycle completes normally.
- RESET asserted in any state forces IDLE and the reset output values on the next edge.
- Counter width is $clog2(max(SETUP_CYC, STROBE_CYC, ROM_CYC, IORDY_TIMEOUT)) + 1. The counter reloads on every state entry and never wraps.

Optional Feature:
- IDE_IORDY_EN defined: in the last STROBE cycle, if IORDY = 0, remain in STROBE and count extension cycles. Exit to ACK when IORDY = 1 or after IORDY_TIMEOUT extension cycles, whichever comes first.
- IDE_IORDY_EN undefined: IORDY is ignored and STROBE is exactly STROBE_CYC cycles.

Decomposition:
- Package ide_cycle_pkg contains:
  - the state enum;
  - REGION_ROM = 1'b0 and REGION_ATA = 1'b1;
  - the cycle-count parameter defaults.
- One sub-module, sync2: a 2-flop synchroniser used for AS_CPU_n.

Test Plan:
- Window miss: BASE_IDE = E9 with IDE_CONFIGURED_n = 1, read at $E98000 → FSM stays IDLE, all outputs inactive, DTACK_n = 1 throughout.
- ATA read: BASE_IDE = E9 with IDE_CONFIGURED_n = 0, read at $E98000 → CS0_n low 3 edges after AS falls. IOR_n low for exactly 3 cycles, BUF_DIR = 1, DTACK_n low until AS negates.
- ATA write: write at $E99000 → CS1_n low, IOW_n low for 3 cycles, BUF_DIR = 0, CS1_n held 1 cycle after IOW_n rises.
- ROM read: ROM_EN = 1, read at $E90010 → ROM_OE_n low for 2 cycles, then DTACK_n. Same read with ROM_EN = 0 → DTACK_n after 1 cycle, ROM_OE_n stays high.
- Abort and reset: AS negated during STROBE → IDLE next edge with no DTACK. RESET pulsed during WAIT_AS → all outputs at reset values on the next edge.
- IORDY (IDE_IORDY_EN defined): IORDY held low → IOR_n stays low for 3+16 cycles then times out. IORDY released after 5 extra cycles → strobe totals 3+5 cycles.
